// File: rtl/ysyx_22040088_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_pkg
// Description : Shared operand-select bit positions, select widths and a
//               one-hot helper used by the operand-select stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040088_pkg;

    localparam int SEL1_W    = 3;
    localparam int SEL2_W    = 5;

    localparam int SEL1_RS1  = 0;
    localparam int SEL1_PC   = 1;
    localparam int SEL1_ZERO = 2;

    localparam int SEL2_RS2  = 0;
    localparam int SEL2_IMMI = 1;
    localparam int SEL2_IMMU = 2;
    localparam int SEL2_FOUR = 3;
    localparam int SEL2_IMMS = 4;

    typedef logic [SEL1_W-1:0] sel1_t;
    typedef logic [SEL2_W-1:0] sel2_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040088_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_fwd_unit
// Description : Register-operand bypass select; EX result beats MEM result,
//               and register x0 is never bypassed.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_fwd_unit #(
    parameter int XLEN = 64,
    parameter int IDXW = 5
) (
    input  logic [IDXW-1:0] rs,
    input  logic [XLEN-1:0] rdata,
    input  logic            ex_wen,
    input  logic [IDXW-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_wen,
    input  logic [IDXW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] fwd_data
);

    logic w_rs_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_rs_nz   = (rs != '0);
    assign w_ex_hit  = w_rs_nz && ex_wen  && (ex_rd  == rs);
    assign w_mem_hit = w_rs_nz && mem_wen && (mem_rd == rs);

    always_comb begin
        fwd_data = rdata;
        if (w_ex_hit) begin
            fwd_data = ex_data;
        end else if (w_mem_hit) begin
            fwd_data = mem_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040088_opsel_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_opsel_stage
// Description : Operand-select pipeline stage: bypasses rs1/rs2, builds ALU
//               sources through AND-OR muxes and registers them behind a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_opsel_stage
    import ysyx_22040088_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_rdata1,
    input  logic [XLEN-1:0]         in_rdata2,
    input  logic [XLEN-1:0]         in_immI,
    input  logic [XLEN-1:0]         in_immU,
    input  logic [XLEN-1:0]         in_immS,
    input  logic [$clog2(NREG)-1:0] in_rs1,
    input  logic [$clog2(NREG)-1:0] in_rs2,
    input  logic [SEL1_W-1:0]       in_sel1,
    input  logic [SEL2_W-1:0]       in_sel2,
    input  logic                    fwd_ex_wen,
    input  logic [$clog2(NREG)-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]         fwd_ex_data,
    input  logic                    fwd_mem_wen,
    input  logic [$clog2(NREG)-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]         fwd_mem_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_src1,
    output logic [XLEN-1:0]         out_src2,
    output logic [XLEN-1:0]         out_store_data,
    output logic                    out_sel_err
);

    localparam int IDXW = $clog2(NREG);
    localparam logic [XLEN-1:0] c_four = XLEN'(4);

    logic            r_valid;
    logic [XLEN-1:0] r_src1;
    logic [XLEN-1:0] r_src2;
    logic [XLEN-1:0] r_store_data;
    logic            r_sel_err;

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;
    logic            w_sel_err;
    logic            w_capture;

    ysyx_22040088_fwd_unit #(
        .XLEN (XLEN),
        .IDXW (IDXW)
    ) u_fwd_rs1 (
        .rs       (in_rs1),
        .rdata    (in_rdata1),
        .ex_wen   (fwd_ex_wen),
        .ex_rd    (fwd_ex_rd),
        .ex_data  (fwd_ex_data),
        .mem_wen  (fwd_mem_wen),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .fwd_data (w_rs1_val)
    );

    ysyx_22040088_fwd_unit #(
        .XLEN (XLEN),
        .IDXW (IDXW)
    ) u_fwd_rs2 (
        .rs       (in_rs2),
        .rdata    (in_rdata2),
        .ex_wen   (fwd_ex_wen),
        .ex_rd    (fwd_ex_rd),
        .ex_data  (fwd_ex_data),
        .mem_wen  (fwd_mem_wen),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .fwd_data (w_rs2_val)
    );

    // Malformed selects OR their sources together rather than prioritising,
    // so the zero select needs no term of its own.
    assign w_src1 = ({XLEN{in_sel1[SEL1_RS1]}} & w_rs1_val)
                  | ({XLEN{in_sel1[SEL1_PC]}}  & in_pc);

    assign w_src2 = ({XLEN{in_sel2[SEL2_RS2]}}  & w_rs2_val)
                  | ({XLEN{in_sel2[SEL2_IMMI]}} & in_immI)
                  | ({XLEN{in_sel2[SEL2_IMMU]}} & in_immU)
                  | ({XLEN{in_sel2[SEL2_FOUR]}} & c_four)
                  | ({XLEN{in_sel2[SEL2_IMMS]}} & in_immS);

    assign w_sel_err = !is_onehot({{(8-SEL1_W){1'b0}}, in_sel1})
                    || !is_onehot({{(8-SEL2_W){1'b0}}, in_sel2});

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_store_data <= '0;
            r_sel_err    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= 1'b1;
            r_src1       <= w_src1;
            r_src2       <= w_src2;
            r_store_data <= w_rs2_val;
            r_sel_err    <= w_sel_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_src1       = r_src1;
    assign out_src2       = r_src2;
    assign out_store_data = r_store_data;
    assign out_sel_err    = r_sel_err;

endmodule
`default_nettype wire
